// File: rtl/register_reader.sv
// register_reader: loads a parallel word and shifts it out MSB first, one bit per enabled clock edge.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   start_i      frame request, sampled only in IDLE
//   d_i          parallel word captured when the frame is accepted
//   en_i         shift enable, one bit consumed per rising edge while high
//   ser_o        current serial bit, MSB first
//   ser_valid_o  ser_o is valid this cycle
//   last_o       current bit is the final bit of the frame
//   busy_o       high in any state other than IDLE
//   done_o       one-cycle pulse after the final bit is consumed
//
// Build option: define REGISTER_READER_PARITY_EN to append an even-parity bit to every frame.
module register_reader #(
    parameter int SIZE = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [SIZE-1:0] d_i,
    input  logic            en_i,
    output logic            ser_o,
    output logic            ser_valid_o,
    output logic            last_o,
    output logic            busy_o,
    output logic            done_o
);
    // SIZE = 1 still needs a one-bit counter that simply stays at zero.
    localparam int CW = SIZE > 1 ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
`ifdef REGISTER_READER_PARITY_EN
        PARITY = 2'd2,
`endif
        DONE   = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [SIZE-1:0] sh;
    logic [CW-1:0]   cnt;
`ifdef REGISTER_READER_PARITY_EN
    logic            par;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sh  <= '0;
            cnt <= '0;
`ifdef REGISTER_READER_PARITY_EN
            par <= 1'b0;
`endif
        end else if (state == IDLE && start_i) begin
            sh  <= d_i;
            cnt <= CW'(SIZE - 1);
`ifdef REGISTER_READER_PARITY_EN
            par <= ^d_i;
`endif
        end else if (state == SHIFT && en_i) begin
            sh  <= sh << 1;
            cnt <= cnt - CW'(1);
        end
    end

    always_comb begin
        state_n     = state;
        ser_o       = 1'b0;
        ser_valid_o = 1'b0;
        last_o      = 1'b0;
        busy_o      = state != IDLE;
        done_o      = 1'b0;
        case (state)
            IDLE: state_n = start_i ? SHIFT : IDLE;
            SHIFT: begin
                ser_o       = sh[SIZE-1];
                ser_valid_o = en_i;
`ifdef REGISTER_READER_PARITY_EN
                state_n     = (en_i && cnt == '0) ? PARITY : SHIFT;
`else
                last_o      = cnt == '0;
                state_n     = (en_i && cnt == '0) ? DONE : SHIFT;
`endif
            end
`ifdef REGISTER_READER_PARITY_EN
            PARITY: begin
                ser_o       = par;
                ser_valid_o = en_i;
                last_o      = 1'b1;
                state_n     = en_i ? DONE : PARITY;
            end
`endif
            DONE: begin
                done_o  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_register_reader.sv
// tb_register_reader: directed self-checking bench for register_reader (SIZE=8 and SIZE=1 instances).
module tb_register_reader;
`ifdef REGISTER_READER_PARITY_EN
    localparam int NB  = 9;
    localparam int NB1 = 2;
`else
    localparam int NB  = 8;
    localparam int NB1 = 1;
`endif

    logic       clk = 0, rst = 0, start = 0, en = 0;
    logic [7:0] d = 0;
    logic       ser, sv, last, busy, done;
    logic       start1 = 0, en1 = 0;
    logic [0:0] d1 = 0;
    logic       ser1, sv1, last1, busy1, done1;
    int         checks = 0, errors = 0;

    register_reader #(.SIZE(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .d_i(d), .en_i(en),
        .ser_o(ser), .ser_valid_o(sv), .last_o(last), .busy_o(busy), .done_o(done)
    );

    register_reader #(.SIZE(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .d_i(d1), .en_i(en1),
        .ser_o(ser1), .ser_valid_o(sv1), .last_o(last1), .busy_o(busy1), .done_o(done1)
    );

    always #5 clk = ~clk;

    function automatic logic exp_bit(input logic [7:0] w, input int i);
        return i < 8 ? w[7-i] : ^w;
    endfunction

    task automatic test_reset;
        #1 rst = 1;
        #1;
        checks++;
        if ({ser, sv, last, busy, done} !== 5'b0) begin
            errors++;
            $display("FAIL reset8: got %b exp 00000", {ser, sv, last, busy, done});
        end
        checks++;
        if ({ser1, sv1, last1, busy1, done1} !== 5'b0) begin
            errors++;
            $display("FAIL reset1: got %b exp 00000", {ser1, sv1, last1, busy1, done1});
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_basic;
        logic [7:0] w = 8'hA5;
        @(negedge clk);
        start = 1; d = w; en = 1;
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            start = 0; d = 8'h00;
            #1;
            checks++;
            if ({sv, ser, last, busy} !== {1'b1, exp_bit(w, i), i == NB - 1, 1'b1}) begin
                errors++;
                $display("FAIL basic bit%0d: got v/s/l/b=%b exp %b", i, {sv, ser, last, busy},
                         {1'b1, exp_bit(w, i), i == NB - 1, 1'b1});
            end
        end
        @(negedge clk); #1;
        checks++;
        if ({done, sv, ser, last, busy} !== 5'b10001) begin
            errors++;
            $display("FAIL basic done: got d/v/s/l/b=%b exp 10001", {done, sv, ser, last, busy});
        end
        @(negedge clk); #1;
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL basic idle: got d/b=%b exp 00", {done, busy});
        end
    endtask

    task automatic test_stall;
        logic [7:0] w = 8'h80;
        int b = 0, c = 0;
        @(negedge clk);
        start = 1; d = w; en = 1;
        while (b < NB && c < 40) begin
            @(negedge clk);
            start = 0;
            c++;
            en = !(c >= 2 && c <= 4);
            #1;
            checks++;
            if ({sv, ser, last, busy} !== {en, exp_bit(w, b), b == NB - 1, 1'b1}) begin
                errors++;
                $display("FAIL stall cyc%0d: got v/s/l/b=%b exp %b", c, {sv, ser, last, busy},
                         {en, exp_bit(w, b), b == NB - 1, 1'b1});
            end
            if (en) b++;
        end
        checks++;
        if (c != NB + 3) begin
            errors++;
            $display("FAIL stall length: got %0d cycles exp %0d", c, NB + 3);
        end
        en = 1;
        @(negedge clk); #1;
        checks++;
        if ({done, sv} !== 2'b10) begin
            errors++;
            $display("FAIL stall done: got d/v=%b exp 10", {done, sv});
        end
        @(negedge clk);
    endtask

    task automatic test_start_held;
        logic [7:0] w = 8'h3C;
        int k = 0;
        @(negedge clk);
        start = 1; d = w; en = 1;
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            d = d + 8'h35;
            #1;
            checks++;
            if ({sv, ser, last} !== {1'b1, exp_bit(w, i), i == NB - 1}) begin
                errors++;
                $display("FAIL held bit%0d: got v/s/l=%b exp %b", i, {sv, ser, last},
                         {1'b1, exp_bit(w, i), i == NB - 1});
            end
        end
        @(negedge clk);
        d = 8'hC3;
        #1;
        checks++;
        if ({done, busy} !== 2'b11) begin
            errors++;
            $display("FAIL held done: got d/b=%b exp 11", {done, busy});
        end
        @(negedge clk); #1;
        checks++;
        if ({busy, done, sv} !== 3'b000) begin
            errors++;
            $display("FAIL held idle gap: got b/d/v=%b exp 000", {busy, done, sv});
        end
        @(negedge clk);
        start = 0; d = 8'h00;
        #1;
        checks++;
        if ({sv, ser, busy} !== 3'b111) begin
            errors++;
            $display("FAIL held second start: got v/s/b=%b exp 111", {sv, ser, busy});
        end
        while (!done && k < 30) begin
            @(negedge clk); #1;
            k++;
        end
        checks++;
        if (k != NB) begin
            errors++;
            $display("FAIL held second frame: done after %0d cycles exp %0d", k, NB);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [7:0] w = 8'h0F;
        @(negedge clk);
        start = 1; d = 8'hE7; en = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 0;
        end
        @(negedge clk);
        #1 rst = 1;
        #1;
        checks++;
        if ({ser, sv, last, busy, done} !== 5'b0) begin
            errors++;
            $display("FAIL midreset async: got %b exp 00000", {ser, sv, last, busy, done});
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({done, busy} !== 2'b00) begin
                errors++;
                $display("FAIL midreset hold%0d: got d/b=%b exp 00", i, {done, busy});
            end
        end
        rst = 0;
        @(negedge clk);
        start = 1; d = w;
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            start = 0;
            #1;
            checks++;
            if ({sv, ser, last} !== {1'b1, exp_bit(w, i), i == NB - 1}) begin
                errors++;
                $display("FAIL midreset bit%0d: got v/s/l=%b exp %b", i, {sv, ser, last},
                         {1'b1, exp_bit(w, i), i == NB - 1});
            end
        end
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL midreset done: got %b exp 1", done);
        end
        @(negedge clk);
    endtask

`ifdef REGISTER_READER_PARITY_EN
    task automatic test_parity;
        logic [7:0] ws [2] = '{8'h07, 8'h03};
        logic       ps [2] = '{1'b1, 1'b0};
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            start = 1; d = ws[t]; en = 1;
            for (int i = 0; i < NB; i++) begin
                @(negedge clk);
                start = 0;
            end
            #1;
            checks++;
            if ({sv, ser, last} !== {1'b1, ps[t], 1'b1}) begin
                errors++;
                $display("FAIL parity %h: got v/s/l=%b exp %b", ws[t], {sv, ser, last}, {1'b1, ps[t], 1'b1});
            end
            @(negedge clk); #1;
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL parity %h done: got %b exp 1", ws[t], done);
            end
            @(negedge clk);
        end
    endtask
`endif

    task automatic test_size1;
        for (int t = 1; t >= 0; t--) begin
            @(negedge clk);
            start1 = 1; d1 = 1'(t); en1 = 1;
            for (int i = 0; i < NB1; i++) begin
                @(negedge clk);
                start1 = 0;
                #1;
                checks++;
                if ({sv1, ser1, last1, busy1} !== {1'b1, 1'(t), i == NB1 - 1, 1'b1}) begin
                    errors++;
                    $display("FAIL size1 d=%0d bit%0d: got v/s/l/b=%b exp %b", t, i,
                             {sv1, ser1, last1, busy1}, {1'b1, 1'(t), i == NB1 - 1, 1'b1});
                end
            end
            @(negedge clk); #1;
            checks++;
            if ({done1, sv1, busy1} !== 3'b101) begin
                errors++;
                $display("FAIL size1 d=%0d done: got d/v/b=%b exp 101", t, {done1, sv1, busy1});
            end
            @(negedge clk); #1;
            checks++;
            if (busy1 !== 1'b0) begin
                errors++;
                $display("FAIL size1 d=%0d idle: got busy %b exp 0", t, busy1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_start_held();
        test_reset_mid();
`ifdef REGISTER_READER_PARITY_EN
        test_parity();
`endif
        test_size1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
